// File: rtl/pid_param_sequencer_pkg.sv
// Shared constants for the PID parameter sequencer: host address map, CTRL
// bit positions, sequencer state encoding and the default PID_16 core timing.
package pid_param_sequencer_pkg;

    localparam int PID16_WIDTH    = 16;
    localparam int PID16_SHIFT    = 5;
    localparam int PID16_PIPE_LAT = 12;
    localparam int FLUSH_CYCLES   = 2;

    localparam logic [2:0] ADDR_K0    = 3'd0;
    localparam logic [2:0] ADDR_K1    = 3'd1;
    localparam logic [2:0] ADDR_K2    = 3'd2;
    localparam logic [2:0] ADDR_SHIFT = 3'd3;
    localparam logic [2:0] ADDR_MIN   = 3'd4;
    localparam logic [2:0] ADDR_MAX   = 3'd5;
    localparam logic [2:0] ADDR_CTRL  = 3'd6;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_COMMIT   = 1;
    localparam int CTRL_CLR_HIST = 2;
    localparam int CTRL_CLR_ERR  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pid_param_sequencer_if.sv
// Host write port of the PID parameter sequencer: one word per accepted cycle,
// accepted when i_wr_en and o_wr_ready are both high.
interface pid_param_sequencer_if;

    logic        i_wr_en;
    logic [2:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic        o_wr_ready;

    modport master (output i_wr_en, output i_wr_addr, output i_wr_data, input o_wr_ready);
    modport slave  (input i_wr_en, input i_wr_addr, input i_wr_data, output o_wr_ready);

endinterface

// File: rtl/pid_param_bank.sv
// Shadow/active parameter pair: host writes land in the shadows, a commit
// copies all six shadows into the active set that drives the PID core.
module pid_param_bank
    import pid_param_sequencer_pkg::*;
#(
    parameter int Width = PID16_WIDTH,
    parameter int Shift = PID16_SHIFT
) (
    input  logic                      i_clkp,
    input  logic                      i_rstn,
    input  logic                      i_wr_en,
    input  logic [2:0]                i_wr_addr,
    input  logic [31:0]               i_wr_data,
    input  logic                      i_commit,
    output logic                      o_shadow_ok,
    output logic signed [Width-1:0]   o_k0,
    output logic signed [Width-1:0]   o_k1,
    output logic signed [Width-1:0]   o_k2,
    output logic [Shift-1:0]          o_shift,
    output logic signed [2*Width-1:0] o_min,
    output logic signed [2*Width-1:0] o_max
);

    localparam int LimW = 2 * Width;

    logic signed [Width-1:0] r_sh_k0, r_sh_k1, r_sh_k2;
    logic [Shift-1:0]        r_sh_shift;
    logic signed [LimW-1:0]  r_sh_min, r_sh_max;

    logic signed [Width-1:0] r_k0, r_k1, r_k2;
    logic [Shift-1:0]        r_shift;
    logic signed [LimW-1:0]  r_min, r_max;

    // An all-zero limit pair means "no limiting" and is accepted as-is.
    assign o_shadow_ok = (r_sh_min < r_sh_max) || ((r_sh_min == '0) && (r_sh_max == '0));

    always_ff @(posedge i_clkp) begin
        if (!i_rstn) begin
            r_sh_k0    <= '0;
            r_sh_k1    <= '0;
            r_sh_k2    <= '0;
            r_sh_shift <= '0;
            r_sh_min   <= '0;
            r_sh_max   <= '0;
            r_k0       <= '0;
            r_k1       <= '0;
            r_k2       <= '0;
            r_shift    <= '0;
            r_min      <= '0;
            r_max      <= '0;
        end else begin
            if (i_wr_en) begin
                case (i_wr_addr)
                    ADDR_K0:    r_sh_k0    <= Width'(i_wr_data);
                    ADDR_K1:    r_sh_k1    <= Width'(i_wr_data);
                    ADDR_K2:    r_sh_k2    <= Width'(i_wr_data);
                    ADDR_SHIFT: r_sh_shift <= Shift'(i_wr_data);
                    ADDR_MIN:   r_sh_min   <= LimW'($signed(i_wr_data));
                    ADDR_MAX:   r_sh_max   <= LimW'($signed(i_wr_data));
                    default:    ;
                endcase
            end
            if (i_commit) begin
                r_k0    <= r_sh_k0;
                r_k1    <= r_sh_k1;
                r_k2    <= r_sh_k2;
                r_shift <= r_sh_shift;
                r_min   <= r_sh_min;
                r_max   <= r_sh_max;
            end
        end
    end

    assign o_k0    = r_k0;
    assign o_k1    = r_k1;
    assign o_k2    = r_k2;
    assign o_shift = r_shift;
    assign o_min   = r_min;
    assign o_max   = r_max;

endmodule

// File: rtl/pid_param_sequencer.sv
// PID parameter sequencer: commits host-written gains/limits and walks the PID
// core through reset flush and pipeline settle before flagging its output valid.
module pid_param_sequencer
    import pid_param_sequencer_pkg::*;
#(
    parameter int Width   = PID16_WIDTH,
    parameter int Shift   = PID16_SHIFT,
    parameter int PipeLat = PID16_PIPE_LAT
) (
    input  logic                      i_clkp,
    input  logic                      i_rstn,
    pid_param_sequencer_if.slave      if_host,
    output logic signed [Width-1:0]   o_k0,
    output logic signed [Width-1:0]   o_k1,
    output logic signed [Width-1:0]   o_k2,
    output logic [Shift-1:0]          o_shift,
    output logic signed [2*Width-1:0] o_min,
    output logic signed [2*Width-1:0] o_max,
    output logic                      o_pid_rstn,
    output logic                      o_valid,
    output logic                      o_err,
    output logic [7:0]                o_commit_cnt
);

    localparam int CntW = (PipeLat > 1) ? $clog2(PipeLat) : 1;
    localparam logic [CntW-1:0] SETTLE_LOAD = CntW'(PipeLat - 1);
    localparam logic [CntW-1:0] FLUSH_LOAD  = CntW'(FLUSH_CYCLES - 1);

    seq_state_t      r_state;
    logic [CntW-1:0] r_cnt;
    logic            r_en;
    logic            r_pid_rstn;
    logic            r_valid;
    logic            r_err;
    logic [7:0]      r_commit_cnt;
    logic            r_wr_ready;

    logic w_accept, w_ctrl, w_en_next, w_commit_bit, w_clr_hist, w_clr_err;
    logic w_commit_req, w_commit_ok, w_err_set, w_shadow_ok;

    assign w_accept     = if_host.i_wr_en && r_wr_ready;
    assign w_ctrl       = w_accept && (if_host.i_wr_addr == ADDR_CTRL);
    assign w_en_next    = w_ctrl ? if_host.i_wr_data[CTRL_EN] : r_en;
    assign w_commit_bit = w_ctrl && if_host.i_wr_data[CTRL_COMMIT];
    assign w_clr_hist   = w_ctrl && if_host.i_wr_data[CTRL_CLR_HIST];
    assign w_clr_err    = w_ctrl && if_host.i_wr_data[CTRL_CLR_ERR];

    // IDLE commits on its own once enabled with a usable shadow set.
    assign w_commit_req = (r_state == ST_IDLE) || w_commit_bit;
    assign w_commit_ok  = w_commit_req && w_en_next && w_shadow_ok;
    assign w_err_set    = w_commit_bit && !w_shadow_ok;

    pid_param_bank #(
        .Width (Width),
        .Shift (Shift)
    ) u_bank (
        .i_clkp      (i_clkp),
        .i_rstn      (i_rstn),
        .i_wr_en     (w_accept),
        .i_wr_addr   (if_host.i_wr_addr),
        .i_wr_data   (if_host.i_wr_data),
        .i_commit    (w_commit_ok),
        .o_shadow_ok (w_shadow_ok),
        .o_k0        (o_k0),
        .o_k1        (o_k1),
        .o_k2        (o_k2),
        .o_shift     (o_shift),
        .o_min       (o_min),
        .o_max       (o_max)
    );

    always_ff @(posedge i_clkp) begin
        if (!i_rstn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_en         <= 1'b0;
            r_pid_rstn   <= 1'b0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_commit_cnt <= '0;
            r_wr_ready   <= 1'b1;
        end else begin
            r_en <= w_en_next;
            if (w_commit_ok) r_commit_cnt <= r_commit_cnt + 8'd1;
            if (w_err_set) r_err <= 1'b1;
            else if (w_clr_err) r_err <= 1'b0;

            if (!w_en_next) begin
                r_state    <= ST_IDLE;
                r_cnt      <= '0;
                r_pid_rstn <= 1'b0;
                r_valid    <= 1'b0;
                r_wr_ready <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_commit_ok) begin
                            r_state    <= ST_FLUSH;
                            r_cnt      <= FLUSH_LOAD;
                            r_wr_ready <= 1'b0;
                        end
                    end
                    ST_FLUSH: begin
                        if (r_cnt == '0) begin
                            r_state    <= ST_SETTLE;
                            r_cnt      <= SETTLE_LOAD;
                            r_pid_rstn <= 1'b1;
                            r_wr_ready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CntW'(1);
                        end
                    end
                    ST_SETTLE: begin
                        if (w_commit_ok && w_clr_hist) begin
                            r_state    <= ST_FLUSH;
                            r_cnt      <= FLUSH_LOAD;
                            r_pid_rstn <= 1'b0;
                            r_wr_ready <= 1'b0;
                        end else if (r_cnt == '0) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_cnt <= r_cnt - CntW'(1);
                        end
                    end
                    ST_RUN: begin
                        // Clearing history restarts the core; otherwise gains update live.
                        if (w_commit_ok && w_clr_hist) begin
                            r_state    <= ST_FLUSH;
                            r_cnt      <= FLUSH_LOAD;
                            r_pid_rstn <= 1'b0;
                            r_valid    <= 1'b0;
                            r_wr_ready <= 1'b0;
                        end else begin
                            r_valid <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign if_host.o_wr_ready = r_wr_ready;
    assign o_pid_rstn         = r_pid_rstn;
    assign o_valid            = r_valid;
    assign o_err              = r_err;
    assign o_commit_cnt       = r_commit_cnt;

endmodule

// File: tb/tb_pid_param_sequencer.sv
// Directed bench for pid_param_sequencer: commit/flush/settle timing, in-place
// updates, limit validity table, enable drop, held writes, reset abort, count wrap.
module tb_pid_param_sequencer;
    import pid_param_sequencer_pkg::*;

    localparam int PIPE = 12;
    localparam int LAT  = 2 + PIPE + 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pid_param_sequencer_if bus();

    logic [15:0] k0, k1, k2;
    logic [4:0]  shift;
    logic [31:0] mn, mx;
    logic        pid_rstn, valid, err;
    logic [7:0]  cnt;

    pid_param_sequencer #(.Width(16), .Shift(5), .PipeLat(PIPE)) dut (
        .i_clkp       (clk),
        .i_rstn       (rstn),
        .if_host      (bus),
        .o_k0         (k0),
        .o_k1         (k1),
        .o_k2         (k2),
        .o_shift      (shift),
        .o_min        (mn),
        .o_max        (mx),
        .o_pid_rstn   (pid_rstn),
        .o_valid      (valid),
        .o_err        (err),
        .o_commit_cnt (cnt)
    );

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] mn;
        logic [31:0] mx;
        logic        ok;
    } vec_t;

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a write and holds it until accepted; returns cycles spent held.
    task automatic host_wr(input logic [2:0] a, input logic [31:0] d, output int held);
        held = 0;
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = a;
        bus.i_wr_data = d;
        while (bus.o_wr_ready !== 1'b1 && held < 64) begin
            step(1);
            held++;
        end
        if (held >= 64) begin
            n_total++;
            $display("FAIL wr_timeout addr=%0d: ready stayed %b, expected 1", a, bus.o_wr_ready);
        end
        step(1);
        bus.i_wr_en = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        int held;
        host_wr(a, d, held);
    endtask

    // Called right after the commit edge; reports the cycle index at which
    // pid_rstn and valid first read high.
    task automatic measure(output int rv, output int rp);
        rv = -1;
        rp = -1;
        chkb("flush_start_pid_rstn", pid_rstn, 1'b0);
        chkb("flush_start_valid", valid, 1'b0);
        for (int c = 1; c <= 40 && rv < 0; c++) begin
            step(1);
            if (pid_rstn === 1'b1 && rp < 0) rp = c;
            if (valid === 1'b1) rv = c;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int held, rv, rp, exp_cnt;
        logic [31:0] exp_mn, exp_mx;

        vecs[0] = '{-32'sd5,        32'sd5,        1'b1};
        vecs[1] = '{32'd0,          32'd0,         1'b1};
        vecs[2] = '{32'd7,          32'd7,         1'b0};
        vecs[3] = '{32'sd10,        -32'sd10,      1'b0};
        vecs[4] = '{32'h8000_0000,  32'h7FFF_FFFF, 1'b1};
        vecs[5] = '{32'd0,          32'd1,         1'b1};
        vecs[6] = '{32'h7FFF_FFFF,  32'h8000_0000, 1'b0};
        vecs[7] = '{32'hFFFF_FFFF,  32'd0,         1'b1};

        bus.i_wr_en   = 1'b0;
        bus.i_wr_addr = 3'd0;
        bus.i_wr_data = 32'd0;
        rstn = 1'b0;
        step(2);

        chkw("rst_k0", 32'(k0), 32'd0);
        chkw("rst_min", mn, 32'd0);
        chkw("rst_max", mx, 32'd0);
        chkb("rst_pid_rstn", pid_rstn, 1'b0);
        chkb("rst_valid", valid, 1'b0);
        chkb("rst_err", err, 1'b0);
        chkw("rst_cnt", 32'(cnt), 32'd0);
        chkb("rst_ready", bus.o_wr_ready, 1'b1);

        rstn = 1'b1;
        step(1);

        // First bring-up
        wr(ADDR_K0, 32'd3);
        wr(ADDR_K1, 32'hFFFF_FFFE);
        wr(ADDR_K2, 32'd1);
        wr(ADDR_SHIFT, 32'd3);
        wr(ADDR_MIN, 32'hFFFF_FC18);
        wr(ADDR_MAX, 32'd1000);
        chkw("shadow_only_k0", 32'(k0), 32'd0);
        chkw("shadow_only_min", mn, 32'd0);

        wr(ADDR_CTRL, 32'h3);
        chkw("commit_k0", 32'(k0), 32'd3);
        chkw("commit_k1", 32'(k1), 32'h0000_FFFE);
        chkw("commit_k2", 32'(k2), 32'd1);
        chkw("commit_shift", 32'(shift), 32'd3);
        chkw("commit_min", mn, 32'hFFFF_FC18);
        chkw("commit_max", mx, 32'd1000);
        chkw("commit_cnt1", 32'(cnt), 32'd1);
        chkb("flush_ready_low", bus.o_wr_ready, 1'b0);
        measure(rv, rp);
        chkw("valid_latency", 32'(rv), 32'(LAT));
        chkw("pid_rstn_low_cycles", 32'(rp), 32'd2);

        // In-place gain update
        wr(ADDR_K0, 32'd5);
        wr(ADDR_CTRL, 32'h3);
        chkw("inplace_k0", 32'(k0), 32'd5);
        chkb("inplace_valid", valid, 1'b1);
        chkb("inplace_pid_rstn", pid_rstn, 1'b1);
        chkw("inplace_cnt", 32'(cnt), 32'd2);
        step(1);
        chkb("inplace_valid_held", valid, 1'b1);

        // Invalid limits, then clear-err
        wr(ADDR_MIN, 32'd500);
        wr(ADDR_MAX, 32'd100);
        wr(ADDR_CTRL, 32'h3);
        chkb("bad_lim_err", err, 1'b1);
        chkw("bad_lim_min", mn, 32'hFFFF_FC18);
        chkw("bad_lim_max", mx, 32'd1000);
        chkw("bad_lim_cnt", 32'(cnt), 32'd2);
        chkb("bad_lim_valid", valid, 1'b1);
        wr(ADDR_CTRL, 32'h9);
        chkb("clr_err", err, 1'b0);

        // Limit validity table: CTRL=0xB commits and clears err; set wins on invalid
        exp_cnt = 2;
        exp_mn  = 32'hFFFF_FC18;
        exp_mx  = 32'd1000;
        for (int i = 0; i < 8; i++) begin
            wr(ADDR_MIN, vecs[i].mn);
            wr(ADDR_MAX, vecs[i].mx);
            wr(ADDR_CTRL, 32'hB);
            if (vecs[i].ok) begin
                exp_cnt++;
                exp_mn = vecs[i].mn;
                exp_mx = vecs[i].mx;
            end
            chkb($sformatf("vec%0d_err", i), err, !vecs[i].ok);
            chkw($sformatf("vec%0d_min", i), mn, exp_mn);
            chkw($sformatf("vec%0d_max", i), mx, exp_mx);
            chkw($sformatf("vec%0d_cnt", i), 32'(cnt), 32'(exp_cnt));
            chkb($sformatf("vec%0d_valid", i), valid, 1'b1);
        end

        // Enable drop and re-enable (IDLE auto-commit)
        wr(ADDR_CTRL, 32'h0);
        chkb("disable_valid", valid, 1'b0);
        chkb("disable_pid_rstn", pid_rstn, 1'b0);
        step(3);
        chkb("disable_valid_stays", valid, 1'b0);
        wr(ADDR_CTRL, 32'h1);
        exp_cnt++;
        chkw("reenable_cnt", 32'(cnt), 32'(exp_cnt));
        measure(rv, rp);
        chkw("reenable_latency", 32'(rv), 32'(LAT));

        // Clear-history commit with a write held across the flush
        wr(ADDR_CTRL, 32'h7);
        exp_cnt++;
        chkb("clrh_valid_drop", valid, 1'b0);
        chkb("clrh_ready_low", bus.o_wr_ready, 1'b0);
        chkw("clrh_cnt", 32'(cnt), 32'(exp_cnt));
        host_wr(ADDR_K2, 32'd9, held);
        chkw("held_cycles", 32'(held), 32'd2);
        chkw("held_k2_active_unchanged", 32'(k2), 32'd1);
        rv = 0;
        while (valid !== 1'b1 && rv < 40) begin
            step(1);
            rv++;
        end
        chkb("clrh_valid_back", valid, 1'b1);
        wr(ADDR_CTRL, 32'h3);
        exp_cnt++;
        chkw("held_k2_committed", 32'(k2), 32'd9);
        chkw("held_cnt", 32'(cnt), 32'(exp_cnt));

        // Reset in the middle of SETTLE
        wr(ADDR_CTRL, 32'h7);
        step(5);
        chkb("mid_settle_pid_rstn", pid_rstn, 1'b1);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        chkw("abort_k0", 32'(k0), 32'd0);
        chkw("abort_k2", 32'(k2), 32'd0);
        chkw("abort_shift", 32'(shift), 32'd0);
        chkw("abort_min", mn, 32'd0);
        chkw("abort_max", mx, 32'd0);
        chkb("abort_pid_rstn", pid_rstn, 1'b0);
        chkb("abort_valid", valid, 1'b0);
        chkb("abort_err", err, 1'b0);
        chkw("abort_cnt", 32'(cnt), 32'd0);
        chkb("abort_ready", bus.o_wr_ready, 1'b1);
        step(20);
        chkb("abort_valid_stays", valid, 1'b0);
        chkb("abort_pid_rstn_stays", pid_rstn, 1'b0);

        // Commit counter wrap (zeroed shadows are a valid "no limit" pair)
        for (int i = 0; i < 255; i++) wr(ADDR_CTRL, 32'h3);
        chkw("cnt_255", 32'(cnt), 32'd255);
        wr(ADDR_CTRL, 32'h3);
        chkw("cnt_wrap", 32'(cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pid_param_sequencer.md
PID_PARAM_SEQUENCER -- requirements
Module: pid_param_sequencer

Interface
REQ-001 Parameter Width, default 16, PID data width; gain width Width, limit width 2*Width.
REQ-002 Parameter Shift, default 5, width of the shift-count field.
REQ-003 Parameter PipeLat, default 12, PID core latency in cycles from i_yt to o_ut.
REQ-004 i_clkp  input  1  system clock; all logic on rising edge.
REQ-005 i_rstn  input  1  reset; synchronous, active-low.
REQ-006 i_wr_en  input  1  host write strobe, one word per asserted cycle.
REQ-007 i_wr_addr  input  3  0=K0, 1=K1, 2=K2, 3=SHIFT, 4=MIN, 5=MAX, 6=CTRL.
REQ-008 i_wr_data  input  32  write data; low Width bits for K0-K2, low Shift bits for SHIFT.
REQ-009 o_wr_ready  output  1  write is accepted when i_wr_en and o_wr_ready are both high.
REQ-010 o_k0, o_k1, o_k2  output  Width  active gains to the PID core.
REQ-011 o_shift  output  Shift  active output shift.
REQ-012 o_min, o_max  output  2*Width  active signed output limits.
REQ-013 o_pid_rstn  output  1  active-low reset to the PID core; registered output.
REQ-014 o_valid  output  1  PID output o_ut is trustworthy.
REQ-015 o_err  output  1  sticky flag: invalid limit pair was committed.
REQ-016 o_commit_cnt  output  8  count of successful commits; wraps 255 to 0.

Function
REQ-017 Each write to addresses 0-5 shall load a shadow register only; active outputs shall change only on commit.
REQ-018 A CTRL write uses these bits: bit0 enable (level, stored), bit1 commit (pulse), bit2 clear-history (pulse, qualifies commit), bit3 clear-err (pulse).
REQ-019 Commit validity: shadow MIN < shadow MAX (signed compare), or MIN = MAX = 0 (no limiting); any other pair is invalid.
REQ-020 A valid commit shall copy all six shadows into the active registers in the cycle after acceptance, and shall increment o_commit_cnt.
REQ-021 An invalid commit shall leave the active registers and o_commit_cnt unchanged, set o_err, and cause no state change.
REQ-022 The FSM has four states: IDLE, FLUSH, SETTLE, RUN.
REQ-023 IDLE: o_pid_rstn=0, o_valid=0; the stored enable=1 with valid shadows performs a commit and moves to FLUSH.
REQ-024 FLUSH: o_pid_rstn=0 for exactly 2 cycles, then SETTLE; o_wr_ready=0 throughout FLUSH.
REQ-025 SETTLE: o_pid_rstn=1 and a down-counter loaded with PipeLat-1 runs; at count 0 the FSM moves to RUN, and o_valid rises the next cycle.
REQ-026 RUN: o_valid=1; a valid commit without clear-history updates the gains in place and stays in RUN with o_valid held.
REQ-027 RUN: a valid commit with clear-history copies the gains, drops o_valid, and moves to FLUSH.
REQ-028 Enable=0 in any state shall move the FSM to IDLE on the next cycle and drop o_valid.
REQ-029 If clear-err and an invalid commit arrive in the same CTRL word, o_err shall end set (set wins).
REQ-030 A shadow write and a commit in the same cycle are impossible (single-port interface); a commit always uses shadows written in earlier cycles.
REQ-031 Writes presented while o_wr_ready=0 shall be ignored and held by the host.

Reset
REQ-032 On i_rstn=0 at a clock edge: FSM=IDLE; shadow and active registers = 0; enable = 0.
REQ-033 On the same reset: o_pid_rstn=0, o_valid=0, o_err=0, o_commit_cnt=0, o_wr_ready=1.
REQ-034 Reset asserted mid-FLUSH or mid-SETTLE shall abort the sequence; the counter shall clear.

Structure
REQ-035 A shared package shall hold the address constants, the CTRL bit indices, the FSM state encoding, and PipeLat for the default PID_16 configuration.
REQ-036 One sub-module, pid_param_bank, shall hold the shadow/active register pair, the commit-validity check, and the copy; the FSM and counters stay at top level.

Verification
REQ-037 Write K0=3, K1=-2, K2=1, MIN=-1000, MAX=1000, then CTRL=0x3 -> o_pid_rstn low 2 cycles, o_valid high exactly 2+PipeLat+1 cycles after the commit cycle, o_commit_cnt=1.
REQ-038 In RUN, write K0=5, then CTRL=0x3 -> o_k0=5 one cycle later, o_valid stays 1, o_pid_rstn stays 1.
REQ-039 In RUN, write MIN=500, MAX=100, then CTRL=0x3 -> o_err=1, o_min/o_max unchanged, then CTRL=0x9 (clear-err) -> o_err=0.
REQ-040 In RUN, CTRL=0x7 -> o_valid falls, 2-cycle flush, settle, o_valid returns; a write attempted during flush is ignored and held.
REQ-041 Assert i_rstn=0 for 1 cycle mid-SETTLE -> all outputs at reset values next cycle, o_valid stays 0 until a new enable.
REQ-042 Issue 256 valid commits -> o_commit_cnt wraps to 0.
